instr_fetch_unit: RTL and testbench

Program-counter and instruction-register block for the PIC16F-compatible core. It answers the decoder's control strobes: `instr_rd_en`, `instr_flush`, `pc_incr_en` and `pc_j_en`, plus call/return/PCL-write strobes. It addresses the synchronous program ROM, latches the fetched word into `instr_current` for the decoder, and maintains the 8-level circular hardware return stack.

---
 rtl/instr_fetch_if.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - decoder/ROM side bus of the instruction fetch unit
//
// Purpose: groups the decoder control strobes, the PCLATH/PCL write data,
// the program ROM address/data pair and the fetch status outputs.
// Ports (signals):
//   strobes      instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
//                pc_call_en, pc_ret_en, pcl_wr_en      (master -> slave)
//   pcl_wr_data  8-bit new PCL value                   (master -> slave)
//   pclath       5-bit PCLATH contents                 (master -> slave)
//   prog_data    14-bit ROM read data                  (master -> slave)
//   prog_addr    ROM address, equal to pc              (slave -> master)
//   instr_current, pc, fetch_ready, stk_ovf, stk_unf   (slave -> master)
interface instr_fetch_if #(
    parameter int PC_WIDTH = 13
);
    logic                instr_rd_en;
    logic                instr_flush;
    logic                pc_incr_en;
    logic                pc_j_en;
    logic                pc_call_en;
    logic                pc_ret_en;
    logic                pcl_wr_en;
    logic [7:0]          pcl_wr_data;
    logic [4:0]          pclath;
    logic [PC_WIDTH-1:0] prog_addr;
    logic [13:0]         prog_data;
    logic [13:0]         instr_current;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_ready;
    logic                stk_ovf;
    logic                stk_unf;

    modport master (
        output instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
               pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data, pclath,
               prog_data,
        input  prog_addr, instr_current, pc, fetch_ready, stk_ovf, stk_unf
    );

    modport slave (
        input  instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
               pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data, pclath,
               prog_data,
        output prog_addr, instr_current, pc, fetch_ready, stk_ovf, stk_unf
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction register and return stack
//
// Purpose: PIC16F-style fetch block. Holds the program counter, addresses
// the synchronous program ROM, latches fetched words into the instruction
// register and keeps the circular hardware return stack.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous, active-high reset
//   bus  instr_fetch_if.slave (strobes in, ROM address and status out)
module instr_fetch_unit #(
    parameter int          PC_WIDTH    = 13,
    parameter int          STACK_DEPTH = 8,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.slave  bus
);
    localparam int SP_W    = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] r_pc;
    logic [13:0]         r_ir;
    logic [SP_W-1:0]     r_sp;
    logic [DEPTH_W-1:0]  r_depth;
    logic                r_fetch_ready;
    logic                r_stk_ovf;
    logic                r_stk_unf;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic [PC_WIDTH-1:0] w_pcl_target;
    logic [SP_W-1:0]     w_sp_dec;
    logic                w_push;
    logic                w_pop;
    logic                w_stack_full;
    logic                w_stack_empty;

    // Jump target uses the IR before this edge's IR update, so a flush on
    // the same edge does not disturb it.
    assign w_jump_target = PC_WIDTH'({bus.pclath[4:3], r_ir[10:0]});
    assign w_pcl_target  = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
    assign w_sp_dec      = r_sp - SP_W'(1);

    // Return wins over call; a simultaneous call performs no push.
    assign w_pop         = bus.pc_ret_en;
    assign w_push        = bus.pc_call_en & ~bus.pc_ret_en;
    assign w_stack_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_stack_empty = (r_depth == '0);

    always_comb begin
        w_pc_next = r_pc;
        if (bus.pc_ret_en)
            w_pc_next = r_stack[w_sp_dec];
        else if (bus.pc_call_en || bus.pc_j_en)
            w_pc_next = w_jump_target;
        else if (bus.pcl_wr_en)
            w_pc_next = w_pcl_target;
        else if (bus.pc_incr_en)
            w_pc_next = r_pc + PC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_ir          <= NOP_WORD;
            r_sp          <= '0;
            r_depth       <= '0;
            r_fetch_ready <= 1'b0;
            r_stk_ovf     <= 1'b0;
            r_stk_unf     <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            // ROM data lags the address by one edge, so it is only valid
            // when pc did not move on the previous edge.
            r_fetch_ready <= (w_pc_next == r_pc);

            if (bus.instr_flush)
                r_ir <= NOP_WORD;
            else if (bus.instr_rd_en)
                r_ir <= bus.prog_data;

            if (w_pop) begin
                r_sp <= w_sp_dec;
                if (w_stack_empty)
                    r_stk_unf <= 1'b1;
                else
                    r_depth <= r_depth - DEPTH_W'(1);
            end else if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
                // Full stack: the oldest entry is overwritten, depth saturates.
                if (w_stack_full)
                    r_stk_ovf <= 1'b1;
                else
                    r_depth <= r_depth + DEPTH_W'(1);
            end
        end
    end

    // Stack contents are not reset; a push coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_stack[r_sp] <= r_pc;
    end

    assign bus.prog_addr     = r_pc;
    assign bus.pc            = r_pc;
    assign bus.instr_current = r_ir;
    assign bus.fetch_ready   = r_fetch_ready;
    assign bus.stk_ovf       = r_stk_ovf;
    assign bus.stk_unf       = r_stk_unf;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [13:0] rom [0:8191];

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(13)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH   (13),
        .STACK_DEPTH(8),
        .NOP_WORD   (14'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous program ROM: one cycle latency.
    always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        bus.instr_rd_en = 1'b0;
        bus.instr_flush = 1'b0;
        bus.pc_incr_en  = 1'b0;
        bus.pc_j_en     = 1'b0;
        bus.pc_call_en  = 1'b0;
        bus.pc_ret_en   = 1'b0;
        bus.pcl_wr_en   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply whatever strobes are set for exactly one edge.
    task automatic edge_go();
        tick();
        clear_strobes();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 14'(14'h3000 + i);
        rom[3] = 14'h2805;

        clear_strobes();
        bus.pclath      = 5'd0;
        bus.pcl_wr_data = 8'd0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_pc", 32'(bus.pc), 32'h0);
        chk("reset_ir", 32'(bus.instr_current), 32'h0);
        chk("reset_fr", 32'(bus.fetch_ready), 32'h0);
        chk("reset_ovf", 32'(bus.stk_ovf), 32'h0);
        chk("reset_unf", 32'(bus.stk_unf), 32'h0);
        chk("reset_addr", 32'(bus.prog_addr), 32'h0);
        rst = 1'b0;
        tick();
        chk("fr_idle", 32'(bus.fetch_ready), 32'h1);

        // Sequential fetch on a 4-cycle cadence.
        for (int k = 0; k < 3; k++) begin
            bus.instr_rd_en = 1'b1;
            bus.pc_incr_en  = 1'b1;
            edge_go();
            chk("seq_ir", 32'(bus.instr_current), 32'h3000 + k);
            chk("seq_pc", 32'(bus.pc), 32'(k + 1));
            chk("seq_fr", 32'(bus.fetch_ready), 32'h0);
            idle(3);
        end
        bus.instr_rd_en = 1'b1;
        bus.pc_incr_en  = 1'b1;
        edge_go();
        chk("goto_ir", 32'(bus.instr_current), 32'h2805);
        idle(3);

        // GOTO 5 with PCLATH[4:3]=2'b11, flushed on the same edge.
        bus.pclath      = 5'b11000;
        bus.instr_flush = 1'b1;
        bus.pc_j_en     = 1'b1;
        edge_go();
        chk("goto_pc", 32'(bus.pc), 32'h1805);
        chk("goto_flush_ir", 32'(bus.instr_current), 32'h0);
        idle(3);
        bus.instr_rd_en = 1'b1;
        bus.pc_incr_en  = 1'b1;
        edge_go();
        chk("goto_fetch_ir", 32'(bus.instr_current), 32'h0805);
        chk("goto_fetch_pc", 32'(bus.pc), 32'h1806);

        // Nine CALLs from 0x0010..0x0018: the ninth overflows.
        bus.pclath = 5'd0;
        for (int k = 0; k < 9; k++) begin
            bus.pcl_wr_data = 8'(8'h10 + k);
            bus.pcl_wr_en   = 1'b1;
            edge_go();
            bus.pc_call_en  = 1'b1;
            bus.instr_flush = 1'b1;
            edge_go();
            if (k == 7) chk("ovf_at_8", 32'(bus.stk_ovf), 32'h0);
            if (k == 8) chk("ovf_at_9", 32'(bus.stk_ovf), 32'h1);
        end
        // Nine RETURNs: 0x18 down to 0x11, then 0x18 again with underflow.
        for (int k = 0; k < 9; k++) begin
            bus.pc_ret_en = 1'b1;
            edge_go();
            chk("ret_pc", 32'(bus.pc), (k == 8) ? 32'h18 : 32'(32'h18 - k));
            if (k == 7) chk("unf_at_8", 32'(bus.stk_unf), 32'h0);
            if (k == 8) chk("unf_at_9", 32'(bus.stk_unf), 32'h1);
        end
        chk("ovf_sticky", 32'(bus.stk_ovf), 32'h1);

        // Computed jump beats increment.
        bus.pclath      = 5'h02;
        bus.pcl_wr_data = 8'h7F;
        bus.pcl_wr_en   = 1'b1;
        bus.pc_incr_en  = 1'b1;
        edge_go();
        chk("pcl_wins", 32'(bus.pc), 32'h027F);

        // Push 0x0100, then call+ret together: ret wins, no push.
        bus.pclath      = 5'h01;
        bus.pcl_wr_data = 8'h00;
        bus.pcl_wr_en   = 1'b1;
        edge_go();
        bus.pc_call_en  = 1'b1;
        bus.instr_flush = 1'b1;
        edge_go();
        bus.pc_call_en = 1'b1;
        bus.pc_ret_en  = 1'b1;
        edge_go();
        chk("callret_pc", 32'(bus.pc), 32'h0100);
        bus.pc_ret_en = 1'b1;
        edge_go();
        chk("callret_nopush", 32'(bus.pc), 32'h0017);

        // Increment wraps at the top of program memory.
        bus.pclath      = 5'h1F;
        bus.pcl_wr_data = 8'hFF;
        bus.pcl_wr_en   = 1'b1;
        edge_go();
        chk("pc_top", 32'(bus.pc), 32'h1FFF);
        bus.pc_incr_en = 1'b1;
        edge_go();
        chk("pc_wrap", 32'(bus.pc), 32'h0000);
        idle(1);
        bus.instr_rd_en = 1'b1;
        edge_go();
        chk("rd_only_ir", 32'(bus.instr_current), 32'h3000);
        bus.instr_rd_en = 1'b1;
        bus.instr_flush = 1'b1;
        edge_go();
        chk("flush_wins_ir", 32'(bus.instr_current), 32'h0);

        // Read right after a jump: fetch_ready low, stale data loaded.
        bus.pclath      = 5'd0;
        bus.pcl_wr_data = 8'h40;
        bus.pcl_wr_en   = 1'b1;
        edge_go();
        chk("fr_after_jump", 32'(bus.fetch_ready), 32'h0);
        if (!bus.fetch_ready)
            $display("note: rd_en issued while fetch_ready=0 (protocol violation)");
        bus.instr_rd_en = 1'b1;
        edge_go();
        chk("stale_ir", 32'(bus.instr_current), 32'h3000);
        idle(3);

        // Reset coinciding with a CALL at depth 3.
        for (int k = 0; k < 3; k++) begin
            bus.pc_call_en  = 1'b1;
            bus.instr_flush = 1'b1;
            edge_go();
        end
        bus.pcl_wr_data = 8'h55;
        bus.pcl_wr_en   = 1'b1;
        edge_go();
        idle(1);
        bus.instr_rd_en = 1'b1;
        edge_go();
        chk("pre_rst_ir", 32'(bus.instr_current), 32'h3055);
        rst            = 1'b1;
        bus.pc_call_en = 1'b1;
        edge_go();
        rst = 1'b0;
        chk("rst_call_pc", 32'(bus.pc), 32'h0);
        chk("rst_call_ir", 32'(bus.instr_current), 32'h0);
        chk("rst_call_ovf", 32'(bus.stk_ovf), 32'h0);
        chk("rst_call_unf", 32'(bus.stk_unf), 32'h0);
        chk("rst_call_fr", 32'(bus.fetch_ready), 32'h0);
        bus.pc_ret_en = 1'b1;
        edge_go();
        chk("rst_depth0_unf", 32'(bus.stk_unf), 32'h1);
        chk("rst_depth0_ovf", 32'(bus.stk_ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
